csh_sweep_ctl: RTL and testbench
================================

Name: csh_sweep_ctl

Overview:
- Cache sweep sequencer for the MBOX cache directory.
- Walks every directory entry (set × way) on command and does, per entry: directory read, optional writeback, optional directory write.
- Sources SWEEP_BUSY and the sweep-done event that the APR error/event logic latches and turns into an interrupt.
- Shares the directory with the core through a grant input. It issues requests only when granted.

Parameters:
- SET_W, 7, set index width (SETS = 2**SET_W).
- WAY_W, 2, way index width (WAYS = 2**WAY_W).
- PAGE_W, 13, directory page-tag width.
- ACK_TIMEOUT, 64, cycles to wait for any ack before the entry is abandoned.

Ports:
- clk  in  1  APR clock.
- RESET  in  1  synchronous, active-high master reset.
- sweep_start  in  1  one-cycle command strobe.
- sweep_func  in  2  00 INVAL, 01 VALIDATE, 10 UNLOAD, 11 treated as UNLOAD; sampled on accept.
- sweep_page_en  in  1  restrict the sweep to one page; sampled on accept.
- sweep_page  in  PAGE_W  page to match; sampled on accept.
- mbox_grant  in  1  directory port free for the sweeper this cycle.
- sweep_mbox_req  out  1  sweeper wants the directory port.
- dir_set  out  SET_W  current set.
- dir_way  out  WAY_W  current way.
- dir_rd_req  out  1  directory read strobe.
- dir_rd_ack  in  1  read data valid.
- dir_valid  in  1  entry valid bit.
- dir_written  in  1  entry written bit.
- dir_page  in  PAGE_W  entry page tag.
- wb_req  out  1  writeback strobe for dir_set/dir_way.
- wb_done  in  1  writeback complete.
- wb_err  in  1  writeback failed; qualified by wb_done.
- dir_wr_req  out  1  directory write strobe.
- dir_wr_valid  out  1  valid bit to write.
- dir_wr_written  out  1  written bit to write.
- dir_wr_ack  in  1  directory write complete.
- sweep_busy  out  1  SWEEP_BUSY.
- sweep_done  out  1  one-cycle done pulse.
- sweep_err  out  1  sticky error.

Behaviour:
- Reset: state IDLE; all outputs 0; entry counter 0; sweep_err 0.
- Reset mid-sweep aborts at once. No sweep_done pulse. Pending acks are ignored.
- Entry counter: ENT_W = SET_W + WAY_W bits, {set, way}, way-minor order. It starts at 0, increments by 1 and ends at 2**ENT_W − 1. There is no wrap; the last entry leads to DONE.
- States: IDLE, RD_REQ, RD_WAIT, WB_REQ, WB_WAIT, WR_REQ, WR_WAIT, NEXT, DONE.
- Start acceptance:
  - sweep_start is accepted only in IDLE or DONE.
  - On accept: latch func/page_en/page, clear sweep_err and the counter, go to RD_REQ.
  - sweep_start in any other state is ignored.
- sweep_busy = 1 in every state except IDLE and DONE.
- sweep_mbox_req = sweep_busy.
- Request states (*_REQ):
  - Wait while mbox_grant = 0.
  - On the first cycle with mbox_grant = 1, drive the matching strobe for exactly one cycle and move to the matching *_WAIT.
- Wait states (*_WAIT):
  - Ack sampled every cycle regardless of grant.
  - A wait-cycle counter is cleared on entry.
  - If ACK_TIMEOUT cycles pass with no ack: set sweep_err and go to NEXT; the entry is abandoned.
  - An ack in the same cycle as the timeout is honoured, not counted as a timeout.
- RD_WAIT decision on dir_rd_ack:
  - hit = dir_valid & (~page_en | dir_page == page).
  - need_wb = hit & dir_written & func != INVAL.
  - need_wr = hit & (func != VALIDATE | dir_written).
  - Next state: WB_REQ if need_wb, else WR_REQ if need_wr, else NEXT.
- WB_WAIT on wb_done:
  - If wb_err: set sweep_err and skip to NEXT. The line stays valid/written.
  - Otherwise go to WR_REQ.
- Directory write data:
  - VALIDATE: valid = 1, written = 0.
  - INVAL / UNLOAD: valid = 0, written = 0.
  - Held stable from WR_REQ through WR_WAIT. dir_set/dir_way are stable through the whole entry.
- NEXT: if the counter is at its last value go to DONE, else increment and go to RD_REQ.
- DONE: sweep_done = 1 for one cycle, then IDLE (or RD_REQ if a start is accepted).
- Timing, all misses, mbox_grant = 1, acks one cycle after the strobe: 3 cycles per entry. Start in cycle 0 gives sweep_busy from cycle 1 and sweep_done at cycle 1 + 3·2**ENT_W.

Decomposition:
- Package csh_sweep_pkg: state enum, sweep_func codes (SWF_INVAL, SWF_VALIDATE, SWF_UNLOAD), ENT_W derivation.
- Sub-module sweep_ack_timer: cycle counter with clear and timeout flag, shared by the three wait states.
- The rest is one FSM plus the counter, inline.

Test Plan:
- SET_W=2, WAY_W=2, all dir_valid = 0, grant = 1, 1-cycle acks, start at cycle 0 → 16 dir_rd_req strobes; no wb_req or dir_wr_req; sweep_busy cycles 1–48; sweep_done only at cycle 49; sweep_err = 0.
- UNLOAD, entry {set 1, way 2} valid + written → one wb_req, then dir_wr_req with valid = 0 and written = 0 at set 1 / way 2. Other valid-clean entries get dir_wr_req only, with no wb_req.
- VALIDATE, page_en = 1, page 0x0A5; entries with page 0x0A5 (written) and 0x0A6 (written) → only the 0x0A5 entry gets wb_req and a directory write of valid = 1, written = 0. The 0x0A6 entry is untouched.
- mbox_grant low for 10 cycles at RD_REQ → no strobe and sweep_busy stays 1. The strobe appears in the first granted cycle, exactly one cycle wide.
- wb_err with wb_done on one entry; dir_rd_ack withheld for 64 cycles on another → sweep_err = 1 and no dir_wr_req for either entry. The sweep completes with sweep_done; the next accepted start clears sweep_err.
- RESET at entry 5 → next cycle sweep_busy = 0 and all outputs 0, with no sweep_done. A start during busy is ignored (counter unaffected). A start during DONE is accepted: sweep_busy = 1 in the following cycle.

Source files
------------

// File: rtl/csh_sweep_pkg.sv
// Shared types for the MBOX cache directory sweep sequencer:
// FSM states, sweep function codes and entry counter width.
package csh_sweep_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WB_REQ,
    ST_WB_WAIT,
    ST_WR_REQ,
    ST_WR_WAIT,
    ST_NEXT,
    ST_DONE
  } sweep_state_e;

  typedef enum logic [1:0] {
    SWF_INVAL    = 2'b00,
    SWF_VALIDATE = 2'b01,
    SWF_UNLOAD   = 2'b10
  } sweep_func_e;

  // Entry counter is {set, way}, so its width is the sum of both index widths.
  function automatic int unsigned ent_width(input int unsigned set_w, input int unsigned way_w);
    return set_w + way_w;
  endfunction

endpackage

// File: rtl/sweep_ack_timer.sv
// Wait-cycle counter shared by the three ack-wait states. Held at zero while
// clr is high; expired is high on the ACK_TIMEOUT-th counted cycle.
module sweep_ack_timer #(
  parameter int ACK_TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic expired
);

  localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ACK_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  // Saturates at LAST so expired stays asserted if the owner lingers.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (cnt != LAST) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/csh_sweep_ctl.sv
// Cache sweep sequencer: walks every directory entry (set x way, way-minor)
// doing a directory read, an optional writeback and an optional directory write.
module csh_sweep_ctl
  import csh_sweep_pkg::*;
#(
  parameter int SET_W       = 7,
  parameter int WAY_W       = 2,
  parameter int PAGE_W      = 13,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              sweep_start,
  input  logic [1:0]        sweep_func,
  input  logic              sweep_page_en,
  input  logic [PAGE_W-1:0] sweep_page,
  input  logic              mbox_grant,
  output logic              sweep_mbox_req,
  output logic [SET_W-1:0]  dir_set,
  output logic [WAY_W-1:0]  dir_way,
  output logic              dir_rd_req,
  input  logic              dir_rd_ack,
  input  logic              dir_valid,
  input  logic              dir_written,
  input  logic [PAGE_W-1:0] dir_page,
  output logic              wb_req,
  input  logic              wb_done,
  input  logic              wb_err,
  output logic              dir_wr_req,
  output logic              dir_wr_valid,
  output logic              dir_wr_written,
  input  logic              dir_wr_ack,
  output logic              sweep_busy,
  output logic              sweep_done,
  output logic              sweep_err,
  output sweep_state_e      dbg_state
);

  localparam int ENT_W = ent_width(SET_W, WAY_W);
  localparam logic [ENT_W-1:0] ENT_LAST = '1;

  sweep_state_e      state, state_nxt;
  logic [ENT_W-1:0]  ent;
  sweep_func_e       func_q;
  logic              page_en_q;
  logic [PAGE_W-1:0] page_q;

  logic accept, ent_inc, err_set;
  logic in_wait, timer_clr, ack_expired;
  logic hit, need_wb, need_wr;

  assign in_wait   = (state == ST_RD_WAIT) || (state == ST_WB_WAIT) || (state == ST_WR_WAIT);
  assign timer_clr = !in_wait;

  sweep_ack_timer #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_ack_timer (
    .clk     (clk),
    .rst     (RESET),
    .clr     (timer_clr),
    .expired (ack_expired)
  );

  assign hit     = dir_valid & (~page_en_q | (dir_page == page_q));
  assign need_wb = hit & dir_written & (func_q != SWF_INVAL);
  assign need_wr = hit & ((func_q != SWF_VALIDATE) | dir_written);

  // Handshake: each *_req strobe is high for exactly one cycle, only while
  // mbox_grant is high; the matching ack/done is sampled every cycle of the
  // following *_WAIT state and an ack on the timeout cycle still counts.
  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    ent_inc    = 1'b0;
    err_set    = 1'b0;
    dir_rd_req = 1'b0;
    wb_req     = 1'b0;
    dir_wr_req = 1'b0;
    case (state)
      ST_IDLE: begin
        if (sweep_start) begin
          accept    = 1'b1;
          state_nxt = ST_RD_REQ;
        end
      end
      ST_RD_REQ: begin
        if (mbox_grant) begin
          dir_rd_req = 1'b1;
          state_nxt  = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (dir_rd_ack) begin
          if (need_wb)      state_nxt = ST_WB_REQ;
          else if (need_wr) state_nxt = ST_WR_REQ;
          else              state_nxt = ST_NEXT;
        end else if (ack_expired) begin
          err_set   = 1'b1;
          state_nxt = ST_NEXT;
        end
      end
      ST_WB_REQ: begin
        if (mbox_grant) begin
          wb_req    = 1'b1;
          state_nxt = ST_WB_WAIT;
        end
      end
      ST_WB_WAIT: begin
        if (wb_done) begin
          if (wb_err) begin
            err_set   = 1'b1;
            state_nxt = ST_NEXT;
          end else begin
            state_nxt = ST_WR_REQ;
          end
        end else if (ack_expired) begin
          err_set   = 1'b1;
          state_nxt = ST_NEXT;
        end
      end
      ST_WR_REQ: begin
        if (mbox_grant) begin
          dir_wr_req = 1'b1;
          state_nxt  = ST_WR_WAIT;
        end
      end
      ST_WR_WAIT: begin
        if (dir_wr_ack) begin
          state_nxt = ST_NEXT;
        end else if (ack_expired) begin
          err_set   = 1'b1;
          state_nxt = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (ent == ENT_LAST) begin
          state_nxt = ST_DONE;
        end else begin
          ent_inc   = 1'b1;
          state_nxt = ST_RD_REQ;
        end
      end
      ST_DONE: begin
        if (sweep_start) begin
          accept    = 1'b1;
          state_nxt = ST_RD_REQ;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state     <= ST_IDLE;
      ent       <= '0;
      func_q    <= SWF_INVAL;
      page_en_q <= 1'b0;
      page_q    <= '0;
      sweep_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        case (sweep_func)
          2'b00:   func_q <= SWF_INVAL;
          2'b01:   func_q <= SWF_VALIDATE;
          default: func_q <= SWF_UNLOAD;
        endcase
        page_en_q <= sweep_page_en;
        page_q    <= sweep_page;
        ent       <= '0;
        sweep_err <= 1'b0;
      end else begin
        if (ent_inc) ent <= ent + 1'b1;
        if (err_set) sweep_err <= 1'b1;
      end
    end
  end

  assign sweep_busy     = (state != ST_IDLE) && (state != ST_DONE);
  assign sweep_mbox_req = sweep_busy;
  assign sweep_done     = (state == ST_DONE);
  assign dir_set        = ent[ENT_W-1:WAY_W];
  assign dir_way        = ent[WAY_W-1:0];
  // Write data depends only on the latched function, so it is stable across WR_REQ/WR_WAIT.
  assign dir_wr_valid   = ((state == ST_WR_REQ) || (state == ST_WR_WAIT)) && (func_q == SWF_VALIDATE);
  assign dir_wr_written = 1'b0;
  assign dbg_state      = state;

endmodule

// File: tb/tb_csh_sweep_ctl.sv
// Directed bench for csh_sweep_ctl with a 16-entry directory (SET_W=2, WAY_W=2):
// table-driven sweeps plus hand sequences for grant stall, reset abort and restart.
module tb_csh_sweep_ctl;
  import csh_sweep_pkg::*;

  localparam int SET_W = 2;
  localparam int WAY_W = 2;
  localparam int PAGE_W = 13;
  localparam int ACK_TIMEOUT = 64;
  localparam int ENTS = 16;
  localparam logic [1:0] EV_RD = 2'd1;
  localparam logic [1:0] EV_WB = 2'd2;
  localparam logic [1:0] EV_WR = 2'd3;

  // ---------------- clock / reset ----------------
  logic clk;
  logic RESET;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic              sweep_start;
  logic [1:0]        sweep_func;
  logic              sweep_page_en;
  logic [PAGE_W-1:0] sweep_page;
  logic              mbox_grant;
  logic              sweep_mbox_req;
  logic [SET_W-1:0]  dir_set;
  logic [WAY_W-1:0]  dir_way;
  logic              dir_rd_req;
  logic              dir_rd_ack;
  logic              dir_valid;
  logic              dir_written;
  logic [PAGE_W-1:0] dir_page;
  logic              wb_req;
  logic              wb_done;
  logic              wb_err;
  logic              dir_wr_req;
  logic              dir_wr_valid;
  logic              dir_wr_written;
  logic              dir_wr_ack;
  logic              sweep_busy;
  logic              sweep_done;
  logic              sweep_err;
  sweep_state_e      dbg_state;

  csh_sweep_ctl #(
    .SET_W(SET_W), .WAY_W(WAY_W), .PAGE_W(PAGE_W), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk(clk), .RESET(RESET),
    .sweep_start(sweep_start), .sweep_func(sweep_func),
    .sweep_page_en(sweep_page_en), .sweep_page(sweep_page),
    .mbox_grant(mbox_grant), .sweep_mbox_req(sweep_mbox_req),
    .dir_set(dir_set), .dir_way(dir_way),
    .dir_rd_req(dir_rd_req), .dir_rd_ack(dir_rd_ack),
    .dir_valid(dir_valid), .dir_written(dir_written), .dir_page(dir_page),
    .wb_req(wb_req), .wb_done(wb_done), .wb_err(wb_err),
    .dir_wr_req(dir_wr_req), .dir_wr_valid(dir_wr_valid),
    .dir_wr_written(dir_wr_written), .dir_wr_ack(dir_wr_ack),
    .sweep_busy(sweep_busy), .sweep_done(sweep_done), .sweep_err(sweep_err),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];
  logic        mon_en = 1'b0;

  // Directory model for the current sweep; pagea entries carry tag 0x0A5, others 0x0A6.
  logic [15:0] cur_valid_m;
  logic [15:0] cur_written_m;
  logic [15:0] cur_pagea_m;
  logic        cur_wv;
  int          slow_ent;
  int          slow_delay;
  int          err_ent;

  typedef struct {
    logic [1:0]  func;
    logic        page_en;
    logic [12:0] page;
    logic [15:0] valid_m;
    logic [15:0] written_m;
    logic [15:0] pagea_m;
    int          slow_ent;
    int          slow_delay;
    int          err_ent;
    logic [15:0] exp_wb;
    logic [15:0] exp_wr;
    logic        exp_wv;
    logic        exp_err;
    int          exp_done;
  } vec_t;

  vec_t vecs[9];

  function automatic vec_t mk(input logic [1:0] func, input logic pe, input logic [12:0] page,
                              input logic [15:0] vm, input logic [15:0] wm, input logic [15:0] am,
                              input int s_ent, input int s_dly, input int e_ent,
                              input logic [15:0] ewb, input logic [15:0] ewr,
                              input logic ewv, input logic eerr, input int edone);
    vec_t v;
    v.func = func; v.page_en = pe; v.page = page;
    v.valid_m = vm; v.written_m = wm; v.pagea_m = am;
    v.slow_ent = s_ent; v.slow_delay = s_dly; v.err_ent = e_ent;
    v.exp_wb = ewb; v.exp_wr = ewr; v.exp_wv = ewv; v.exp_err = eerr; v.exp_done = edone;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic check_event(input logic [7:0] got);
    logic [7:0] exp;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL strobe_event: got %h, expected no strobe (t=%0t)", got, $time);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        n_errors++;
        $display("FAIL strobe_event: got %h, expected %h (t=%0t)", got, exp, $time);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directory / writeback responder and strobe monitor ----------------
  initial begin : responder
    logic       rd_seen, wb_seen, wr_seen, wr_hold;
    logic [3:0] idx, rd_pidx;
    int         rd_pend;
    dir_rd_ack = 1'b0; dir_valid = 1'b0; dir_written = 1'b0; dir_page = '0;
    wb_done = 1'b0; wb_err = 1'b0; dir_wr_ack = 1'b0;
    rd_pend = 0; rd_pidx = '0; wr_hold = 1'b0;
    forever begin
      @(negedge clk);
      rd_seen = dir_rd_req;
      wb_seen = wb_req;
      wr_seen = dir_wr_req;
      idx     = {dir_set, dir_way};
      if (mon_en) begin
        if (wr_hold) check("wr_data_hold", 32'({dir_wr_valid, dir_wr_written}), 32'({cur_wv, 1'b0}));
        if (rd_seen) check_event({EV_RD, idx, 2'b00});
        if (wb_seen) check_event({EV_WB, idx, 2'b00});
        if (wr_seen) check_event({EV_WR, idx, dir_wr_valid, dir_wr_written});
      end
      wr_hold = wr_seen;
      tick();
      dir_rd_ack = 1'b0; dir_valid = 1'b0; dir_written = 1'b0; dir_page = '0;
      wb_done = 1'b0; wb_err = 1'b0; dir_wr_ack = 1'b0;
      if (rd_seen) begin
        rd_pidx = idx;
        rd_pend = (int'(idx) == slow_ent) ? slow_delay : 1;
      end
      if (rd_pend > 0) begin
        rd_pend--;
        if (rd_pend == 0) begin
          dir_rd_ack  = 1'b1;
          dir_valid   = cur_valid_m[rd_pidx];
          dir_written = cur_written_m[rd_pidx];
          dir_page    = cur_pagea_m[rd_pidx] ? 13'h0A5 : 13'h0A6;
        end
      end
      if (wb_seen) begin
        wb_done = 1'b1;
        wb_err  = (int'(idx) == err_ent);
      end
      if (wr_seen) dir_wr_ack = 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_done(output int cyc);
    logic seen;
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 300) begin
      cyc++;
      @(negedge clk);
      seen = sweep_done;
      if (!seen) tick();
    end
  endtask

  task automatic run_vec(input int k);
    vec_t v;
    int   cyc, done_cyc, busy_cnt, first_busy;
    logic err_at_done;
    v = vecs[k];
    cur_valid_m = v.valid_m; cur_written_m = v.written_m; cur_pagea_m = v.pagea_m;
    cur_wv = v.exp_wv; slow_ent = v.slow_ent; slow_delay = v.slow_delay; err_ent = v.err_ent;
    exp_q.delete();
    for (int e = 0; e < ENTS; e++) begin
      exp_q.push_back({EV_RD, 4'(e), 2'b00});
      if (v.exp_wb[e]) exp_q.push_back({EV_WB, 4'(e), 2'b00});
      if (v.exp_wr[e]) exp_q.push_back({EV_WR, 4'(e), v.exp_wv, 1'b0});
    end
    mon_en = 1'b1;
    sweep_start = 1'b1; sweep_func = v.func; sweep_page_en = v.page_en; sweep_page = v.page;
    @(negedge clk);
    tick();
    sweep_start = 1'b0;
    done_cyc = -1; busy_cnt = 0; first_busy = -1; err_at_done = 1'b0; cyc = 1;
    while (done_cyc < 0 && cyc < 400) begin
      @(negedge clk);
      if (cyc == 1) check($sformatf("v%0d_err_cleared", k), 32'(sweep_err), 32'(0));
      if (sweep_busy) begin
        busy_cnt++;
        if (first_busy < 0) first_busy = cyc;
      end
      if (sweep_done) begin
        done_cyc = cyc;
        err_at_done = sweep_err;
      end
      tick();
      cyc++;
    end
    check($sformatf("v%0d_done_cycle", k), 32'(done_cyc), 32'(v.exp_done));
    check($sformatf("v%0d_first_busy", k), 32'(first_busy), 32'(1));
    check($sformatf("v%0d_busy_cycles", k), 32'(busy_cnt), 32'(v.exp_done - 1));
    check($sformatf("v%0d_sweep_err", k), 32'(err_at_done), 32'(v.exp_err));
    @(negedge clk);
    check($sformatf("v%0d_done_one_cycle", k), 32'({sweep_done, sweep_busy}), 32'(0));
    check($sformatf("v%0d_events_left", k), 32'(exp_q.size()), 32'(0));
    mon_en = 1'b0;
    tick();
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int n;
    RESET = 1'b1; sweep_start = 1'b0; sweep_func = 2'b00; sweep_page_en = 1'b0;
    sweep_page = '0; mbox_grant = 1'b1;
    cur_valid_m = '0; cur_written_m = '0; cur_pagea_m = '0; cur_wv = 1'b0;
    slow_ent = -1; slow_delay = 1; err_ent = -1;

    //        func   pe  page    valid    written  pagea    slow dly err  exp_wb   exp_wr   wv eer done
    vecs[0] = mk(2'b00, 0, 13'h000, 16'h0000, 16'h0000, 16'h0000, -1, 1, -1, 16'h0000, 16'h0000, 0, 0, 49);
    vecs[1] = mk(2'b10, 0, 13'h000, 16'h0249, 16'h0040, 16'h0000, -1, 1, -1, 16'h0040, 16'h0249, 0, 0, 59);
    vecs[2] = mk(2'b01, 1, 13'h0A5, 16'h00A4, 16'h0024, 16'h0084, -1, 1, -1, 16'h0004, 16'h0004, 1, 0, 53);
    vecs[3] = mk(2'b00, 0, 13'h000, 16'h0012, 16'h0002, 16'h0000, -1, 1, -1, 16'h0000, 16'h0012, 0, 0, 53);
    vecs[4] = mk(2'b11, 1, 13'h0A6, 16'h0124, 16'h0024, 16'h0004, -1, 1, -1, 16'h0020, 16'h0120, 0, 0, 55);
    vecs[5] = mk(2'b01, 0, 13'h000, 16'h0008, 16'h0408, 16'h0000, -1, 1, -1, 16'h0008, 16'h0008, 1, 0, 53);
    vecs[6] = mk(2'b10, 0, 13'h000, 16'h1002, 16'h1002, 16'h0000, 12, 0,  1, 16'h0002, 16'h0000, 0, 1, 114);
    vecs[7] = mk(2'b00, 0, 13'h000, 16'h0010, 16'h0000, 16'h0000,  4, 64, -1, 16'h0000, 16'h0010, 0, 0, 114);
    vecs[8] = mk(2'b00, 0, 13'h000, 16'h0010, 16'h0000, 16'h0000,  4, 65, -1, 16'h0000, 16'h0000, 0, 1, 112);

    repeat (3) tick();
    RESET = 1'b0;
    @(negedge clk);
    check("reset_outputs", 32'({sweep_mbox_req, dir_set, dir_way, dir_rd_req, wb_req, dir_wr_req,
                                dir_wr_valid, dir_wr_written, sweep_busy, sweep_done, sweep_err}), 32'(0));
    check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    tick();

    for (int k = 0; k < 9; k++) run_vec(k);

    // Grant withheld for 10 cycles at RD_REQ, then reset abort at entry 5.
    cur_valid_m = '0; cur_written_m = '0; slow_ent = -1; slow_delay = 1; err_ent = -1;
    mbox_grant = 1'b0; sweep_start = 1'b1; sweep_func = 2'b10; sweep_page_en = 1'b0;
    @(negedge clk);
    tick();
    sweep_start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      check($sformatf("grant_stall_c%0d", c), 32'({dir_rd_req, sweep_busy, sweep_mbox_req}), 32'(3'b011));
      tick();
    end
    mbox_grant = 1'b1;
    @(negedge clk);
    check("grant_first_strobe", 32'({dir_rd_req, sweep_busy, dir_set, dir_way}), 32'({2'b11, 4'd0}));
    tick();
    @(negedge clk);
    check("grant_strobe_width", 32'({dir_rd_req, sweep_busy}), 32'(2'b01));
    for (int c = 13; c <= 26; c++) begin
      tick();
      sweep_start = (c == 20);
      @(negedge clk);
    end
    check("busy_start_ignored", 32'({dir_rd_req, dir_set, dir_way}), 32'({1'b1, 4'd5}));
    tick();
    sweep_start = 1'b0;
    RESET = 1'b1;
    @(negedge clk);
    tick();
    RESET = 1'b0;
    @(negedge clk);
    check("abort_outputs", 32'({sweep_mbox_req, dir_set, dir_way, dir_rd_req, wb_req, dir_wr_req,
                                dir_wr_valid, dir_wr_written, sweep_busy, sweep_done, sweep_err}), 32'(0));
    for (int c = 0; c < 5; c++) begin
      tick();
      @(negedge clk);
      check($sformatf("abort_quiet_c%0d", c), 32'({sweep_busy, sweep_done}), 32'(0));
    end
    tick();

    // Start accepted in DONE restarts immediately.
    sweep_start = 1'b1; sweep_func = 2'b00;
    @(negedge clk);
    tick();
    sweep_start = 1'b0;
    wait_done(n);
    check("restart_first_done", 32'(n), 32'(49));
    sweep_start = 1'b1; sweep_func = 2'b01;
    tick();
    sweep_start = 1'b0;
    @(negedge clk);
    check("restart_from_done", 32'({sweep_busy, sweep_done, dir_set, dir_way}), 32'({2'b10, 4'd0}));
    tick();
    wait_done(n);
    check("restart_second_done", 32'(n), 32'(48));
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
